// File: rtl/xosera_pkg.sv
// Shared ACIA definitions: transmit FSM states and the bit-period calculation
// used by both the receive and transmit paths.
package xosera_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } acia_tx_state_t;

  function automatic int unsigned bps_count(input int unsigned clk_hz,
                                            input int unsigned bps_rate);
    return clk_hz / bps_rate;
  endfunction

endpackage

// File: rtl/acia_tx_fifo.sv
// Small synchronous first-word-fall-through byte queue for the ACIA transmitter.
module acia_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push while full is dropped even when a pop frees a slot that same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (PW+1)'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/acia_tx.sv
// ACIA transmitter: queued bytes sent as 8N1/8N2 frames with CTS flow control
// and break generation.
module acia_tx
  import xosera_pkg::*;
#(
  parameter int unsigned BPS_RATE   = 115200,
  parameter int unsigned CLK_HZ     = 25125000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic [7:0] tx_dat_i,
  input  logic       tx_stb_i,
  output logic       tx_rdy_o,
  output logic       tx_busy_o,
  input  logic       tx_cts_i,
  input  logic       tx_brk_i,
  output logic       tx_serial_o
);
  localparam int unsigned BPS_COUNT = bps_count(CLK_HZ, BPS_RATE);
  localparam int unsigned CNT_W     = (BPS_COUNT > 1) ? $clog2(BPS_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BPS_COUNT - 1);

  acia_tx_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_stop_left;
  logic             r_mark;
  logic             r_serial;
  logic             r_cts_meta;
  logic             r_cts_sync;

  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic             w_tick;
  logic             w_exit;
  logic             w_pop;

  acia_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (8)
  ) u_fifo (
    .clk    (clk),
    .rst_ni (rst_ni),
    .i_push (tx_stb_i),
    .i_pop  (w_pop),
    .i_din  (tx_dat_i),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // The end of a stop bit or break mark behaves like IDLE, so the next frame
  // can start on that same edge with no gap.
  always_comb begin
    w_tick = (r_cnt == '0);
    w_exit = 1'b0;
    case (r_state)
      IDLE:    w_exit = 1'b1;
      STOP:    w_exit = w_tick && !r_stop_left;
      BREAK:   w_exit = r_mark && w_tick;
      default: w_exit = 1'b0;
    endcase
    w_pop = w_exit && !w_empty && r_cts_sync && !tx_brk_i;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_stop_left <= 1'b0;
      r_mark      <= 1'b0;
      r_serial    <= 1'b1;
      r_cts_meta  <= 1'b0;
      r_cts_sync  <= 1'b0;
    end else begin
      r_cts_meta <= tx_cts_i;
      r_cts_sync <= r_cts_meta;
      if (w_exit) begin
        if (tx_brk_i) begin
          r_state  <= BREAK;
          r_mark   <= 1'b0;
          r_serial <= 1'b0;
        end else if (w_pop) begin
          r_state  <= START;
          r_shift  <= w_head;
          r_cnt    <= CNT_RELOAD;
          r_serial <= 1'b0;
        end else begin
          r_state  <= IDLE;
          r_serial <= 1'b1;
        end
      end else if (r_state == BREAK && !r_mark) begin
        if (!tx_brk_i) begin
          r_mark   <= 1'b1;
          r_serial <= 1'b1;
          r_cnt    <= CNT_RELOAD;
        end
      end else if (!w_tick) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= CNT_RELOAD;
        case (r_state)
          START: begin
            r_state  <= DATA;
            r_bit    <= '0;
            r_serial <= r_shift[0];
          end
          DATA: begin
            if (r_bit == 3'd7) begin
              r_state     <= STOP;
              r_serial    <= 1'b1;
              r_stop_left <= (STOP_BITS == 2);
            end else begin
              r_bit    <= r_bit + 3'd1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_serial <= r_shift[1];
            end
          end
          STOP:    r_stop_left <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign tx_serial_o = r_serial;
  assign tx_rdy_o    = !w_full;
  assign tx_busy_o   = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_acia_tx.sv
// Self-checking bench for acia_tx: line waveforms compared against frames
// built from the 8N1/8N2 framing rules and a timing model of the queue.
module tb_acia_tx;
  localparam int BPS = 16;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] tx_dat_i = '0;
  logic       tx_stb_i = 1'b0;
  logic       tx_cts_i = 1'b0;
  logic       tx_brk_i = 1'b0;
  logic       tx_rdy_o, tx_busy_o, tx_serial_o;
  logic [7:0] d2_dat = '0;
  logic       d2_stb = 1'b0;
  logic       d2_cts = 1'b1;
  logic       d2_brk = 1'b0;
  logic       d2_rdy, d2_busy, d2_serial;

  int n_checks = 0;
  int n_fail = 0;
  logic line_q[$];
  logic busy_q[$];
  logic line2_q[$];
  logic exp_q[$];
  int   first_bad;
  logic first_got, first_want;

  always #5 clk = ~clk;

  acia_tx #(.BPS_RATE(100000), .CLK_HZ(1600000), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst_ni(rst_ni), .tx_dat_i(tx_dat_i), .tx_stb_i(tx_stb_i),
    .tx_rdy_o(tx_rdy_o), .tx_busy_o(tx_busy_o), .tx_cts_i(tx_cts_i),
    .tx_brk_i(tx_brk_i), .tx_serial_o(tx_serial_o));

  acia_tx #(.BPS_RATE(100000), .CLK_HZ(1600000), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_ni(rst_ni), .tx_dat_i(d2_dat), .tx_stb_i(d2_stb),
    .tx_rdy_o(d2_rdy), .tx_busy_o(d2_busy), .tx_cts_i(d2_cts),
    .tx_brk_i(d2_brk), .tx_serial_o(d2_serial));

  // Entry k of each log is the state just after posedge number k.
  always @(posedge clk) begin
    #1;
    line_q.push_back(tx_serial_o);
    busy_q.push_back(tx_busy_o);
    line2_q.push_back(d2_serial);
  end

  function automatic logic frame_level(input logic [7:0] d, input int k);
    int p = k / BPS;
    if (p == 0) return 1'b0;
    if (p <= 8) return d[p-1];
    return 1'b1;
  endfunction

  function automatic void add_frame(input logic [7:0] d, input int stops);
    for (int k = 0; k < BPS * (9 + stops); k++) exp_q.push_back(frame_level(d, k));
  endfunction

  function automatic void add_level(input logic v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endfunction

  function automatic int line_errs(input int base, input bit use2);
    int e = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      logic got = use2 ? line2_q[base+i] : line_q[base+i];
      if (got !== exp_q[i]) begin
        if (e == 0) begin
          first_bad = i; first_got = got; first_want = exp_q[i];
        end
        e++;
      end
    end
    return e;
  endfunction

  // Called at a negedge; the byte is presented to the next posedge.
  task automatic put(input logic [7:0] d, output logic acc);
    acc = tx_rdy_o;
    tx_dat_i = d;
    tx_stb_i = 1'b1;
    @(negedge clk);
    tx_stb_i = 1'b0;
  endtask

  task automatic put2(input logic [7:0] d);
    d2_dat = d;
    d2_stb = 1'b1;
    @(negedge clk);
    d2_stb = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_serial_o, tx_rdy_o, tx_busy_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_outputs: got serial/rdy/busy=%b want 110", {tx_serial_o, tx_rdy_o, tx_busy_o});
    end
    n_checks++;
    if ({d2_serial, d2_rdy, d2_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_outputs_2stop: got %b want 110", {d2_serial, d2_rdy, d2_busy});
    end
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({tx_serial_o, tx_busy_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_after_reset: got serial/busy=%b want 10", {tx_serial_o, tx_busy_o});
    end
  endtask

  task automatic test_single();
    int base, errs;
    logic acc;
    tx_cts_i = 1'b1;
    repeat (3) @(negedge clk);
    base = line_q.size();
    put(8'hA5, acc);
    repeat (170) @(negedge clk);
    exp_q.delete();
    add_level(1'b1, 1); add_frame(8'hA5, 1); add_level(1'b1, 4);
    errs = line_errs(base, 1'b0);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL single_frame: %0d bad samples, first at +%0d got %b want %b", errs, first_bad, first_got, first_want);
    end
    n_checks++;
    if ({busy_q[base+160], busy_q[base+161]} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_busy_drop: got %b want 10", {busy_q[base+160], busy_q[base+161]});
    end
  endtask

  task automatic test_back_to_back();
    int base, errs;
    logic acc;
    logic [4:0] accm;
    base = line_q.size();
    for (int i = 0; i < 5; i++) begin
      put(8'(i), acc);
      accm[i] = acc;
    end
    n_checks++;
    if (accm !== 5'b11111) begin
      n_fail++;
      $display("FAIL b2b_accept: got %b want 11111", accm);
    end
    n_checks++;
    if (tx_rdy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rdy_low: got %b want 0", tx_rdy_o);
    end
    repeat (810) @(negedge clk);
    exp_q.delete();
    add_level(1'b1, 1);
    for (int i = 0; i < 5; i++) add_frame(8'(i), 1);
    add_level(1'b1, 5);
    errs = line_errs(base, 1'b0);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL b2b_frames: %0d bad samples, first at +%0d got %b want %b", errs, first_bad, first_got, first_want);
    end
    n_checks++;
    if ({busy_q[base+800], busy_q[base+801]} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_busy_drop: got %b want 10", {busy_q[base+800], busy_q[base+801]});
    end
  endtask

  task automatic test_full_drop();
    int p, errs;
    logic acc;
    logic [3:0] accm;
    logic [7:0] d [4];
    tx_cts_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      d[i] = 8'($urandom);
      put(d[i], acc);
      accm[i] = acc;
    end
    n_checks++;
    if ({accm, tx_rdy_o} !== 5'b11110) begin
      n_fail++;
      $display("FAIL full_fill: got accepted/rdy=%b want 11110", {accm, tx_rdy_o});
    end
    p = line_q.size();
    tx_cts_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    put(8'hFF, acc);
    n_checks++;
    if (acc !== 1'b0) begin
      n_fail++;
      $display("FAIL full_strobe_rdy: got %b want 0", acc);
    end
    repeat (660) @(negedge clk);
    exp_q.delete();
    add_level(1'b1, 2);
    for (int i = 0; i < 4; i++) add_frame(d[i], 1);
    add_level(1'b1, 10);
    errs = line_errs(p, 1'b0);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL full_drop_frames: %0d bad samples, first at +%0d got %b want %b", errs, first_bad, first_got, first_want);
    end
    n_checks++;
    if ({tx_rdy_o, tx_busy_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_drained: got rdy/busy=%b want 10", {tx_rdy_o, tx_busy_o});
    end
  endtask

  task automatic test_cts();
    int p, q, errs;
    logic acc;
    logic [7:0] b2;
    tx_cts_i = 1'b0;
    repeat (4) @(negedge clk);
    q = line_q.size();
    put(8'h55, acc);
    repeat (20) @(negedge clk);
    errs = 0;
    for (int i = q; i < line_q.size(); i++)
      if (line_q[i] !== 1'b1 || busy_q[i] !== 1'b1) errs++;
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL cts_hold: %0d samples differ, want line=1 busy=1", errs);
    end
    p = line_q.size();
    tx_cts_i = 1'b1;
    repeat (52) @(negedge clk);
    tx_cts_i = 1'b0;
    b2 = 8'($urandom);
    put(b2, acc);
    n_checks++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL cts_midframe_accept: got %b want 1", acc);
    end
    repeat (150) @(negedge clk);
    exp_q.delete();
    add_level(1'b1, 2); add_frame(8'h55, 1); add_level(1'b1, 40);
    errs = line_errs(p, 1'b0);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL cts_frame: %0d bad samples, first at +%0d got %b want %b", errs, first_bad, first_got, first_want);
    end
    n_checks++;
    if (busy_q[p+201] !== 1'b1) begin
      n_fail++;
      $display("FAIL cts_wait_busy: got %b want 1", busy_q[p+201]);
    end
    q = line_q.size();
    tx_cts_i = 1'b1;
    repeat (180) @(negedge clk);
    exp_q.delete();
    add_level(1'b1, 2); add_frame(b2, 1); add_level(1'b1, 10);
    errs = line_errs(q, 1'b0);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL cts_resume: %0d bad samples, first at +%0d got %b want %b", errs, first_bad, first_got, first_want);
    end
  endtask

  task automatic test_break();
    int base, errs;
    logic acc;
    logic [7:0] nb;
    tx_cts_i = 1'b1;
    repeat (4) @(negedge clk);
    base = line_q.size();
    nb = 8'($urandom);
    put(8'h3C, acc);
    put(nb, acc);
    repeat (68) @(negedge clk);
    tx_brk_i = 1'b1;
    repeat (151) @(negedge clk);
    tx_brk_i = 1'b0;
    repeat (260) @(negedge clk);
    exp_q.delete();
    add_level(1'b1, 1); add_frame(8'h3C, 1); add_level(1'b0, 60);
    add_level(1'b1, 16); add_frame(nb, 1); add_level(1'b1, 4);
    errs = line_errs(base, 1'b0);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL break_sequence: %0d bad samples, first at +%0d got %b want %b", errs, first_bad, first_got, first_want);
    end
    n_checks++;
    if (busy_q[base+200] !== 1'b1) begin
      n_fail++;
      $display("FAIL break_busy: got %b want 1", busy_q[base+200]);
    end
  endtask

  task automatic test_stop2();
    int base, errs;
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    base = line2_q.size();
    put2(a);
    put2(b);
    repeat (370) @(negedge clk);
    exp_q.delete();
    add_level(1'b1, 1); add_frame(a, 2); add_frame(b, 2); add_level(1'b1, 5);
    errs = line_errs(base, 1'b1);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL stop2_frames: %0d bad samples, first at +%0d got %b want %b", errs, first_bad, first_got, first_want);
    end
  endtask

  task automatic test_random();
    int st[$];
    int pe[$];
    logic [7:0] dq[$];
    int base, t, s, occ, last_end, gap, errs_l, errs_b;
    logic acc, exp_acc, lv, bv;
    logic [7:0] d;
    tx_cts_i = 1'b1;
    tx_brk_i = 1'b0;
    repeat (4) @(negedge clk);
    base = line_q.size();
    last_end = 0;
    for (int i = 0; i < 12; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 200)) : int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      t = line_q.size();
      occ = 0;
      foreach (st[k]) if (st[k] >= t) occ++;
      exp_acc = (occ < 4);
      d = 8'($urandom);
      put(d, acc);
      n_checks++;
      if (acc !== exp_acc) begin
        n_fail++;
        $display("FAIL rand_accept[%0d]: got %b want %b", i, acc, exp_acc);
      end
      if (exp_acc) begin
        s = (t + 1 > last_end) ? t + 1 : last_end;
        st.push_back(s);
        pe.push_back(t);
        dq.push_back(d);
        last_end = s + 10 * BPS;
      end
    end
    repeat (last_end + 20 - line_q.size()) @(negedge clk);
    errs_l = 0;
    errs_b = 0;
    for (int i = base; i < last_end + 10; i++) begin
      lv = 1'b1;
      bv = 1'b0;
      foreach (st[k]) begin
        if (i >= st[k] && i < st[k] + 10 * BPS) lv = frame_level(dq[k], i - st[k]);
        if (i >= pe[k] && i < st[k] + 10 * BPS) bv = 1'b1;
      end
      if (line_q[i] !== lv) errs_l++;
      if (busy_q[i] !== bv) errs_b++;
    end
    n_checks++;
    if (errs_l != 0) begin
      n_fail++;
      $display("FAIL rand_line: %0d samples differ from model, want 0", errs_l);
    end
    n_checks++;
    if (errs_b != 0) begin
      n_fail++;
      $display("FAIL rand_busy: %0d samples differ from model, want 0", errs_b);
    end
  endtask

  task automatic test_reset_mid();
    int base, r, errs;
    logic acc;
    base = line_q.size();
    put(8'($urandom), acc);
    put(8'($urandom), acc);
    repeat (39) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({tx_serial_o, tx_rdy_o, tx_busy_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got serial/rdy/busy=%b want 110", {tx_serial_o, tx_rdy_o, tx_busy_o});
    end
    r = line_q.size();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (200) @(negedge clk);
    errs = 0;
    for (int i = r; i < line_q.size(); i++)
      if (line_q[i] !== 1'b1 || busy_q[i] !== 1'b0) errs++;
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL reset_discard: %0d samples differ, want line=1 busy=0", errs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_drop();
    test_cts();
    test_break();
    test_stop2();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acia_tx.md
Name: acia_tx

Overview:
Asynchronous serial transmitter for the Xosera ACIA. It is the transmit counterpart of the ACIA receive path and emits 8N1 or 8N2 frames at a fixed bps rate. A small write queue decouples CPU register writes from line timing. The block also supports CTS flow control and break generation. It sits under the ACIA register block and drives the UART TX pin.

Parameters:
BPS_RATE, 115200, line bit rate in bits/s
CLK_HZ, 25125000, clk frequency in Hz; bit period BPS_COUNT = CLK_HZ / BPS_RATE cycles (integer divide)
FIFO_DEPTH, 4, transmit queue depth in bytes; power of two, 2..16
STOP_BITS, 1, number of stop bits; legal values are 1 or 2

Ports:
clk  input  1  system clock; single clock domain
rst_ni  input  1  asynchronous active-low reset; resets all state
tx_dat_i  input  8  byte to transmit
tx_stb_i  input  1  write strobe; byte is enqueued when tx_stb_i && tx_rdy_o
tx_rdy_o  output  1  queue not full
tx_busy_o  output  1  queue non-empty, or frame in progress, or break active
tx_cts_i  input  1  clear-to-send, active high; asynchronous, so double-flopped internally
tx_brk_i  input  1  break request, synchronous level
tx_serial_o  output  1  registered serial line; idle high

Behaviour:
- Reset values:
  - tx_serial_o=1, tx_rdy_o=1, tx_busy_o=0.
  - Queue empty; FSM in IDLE; bit-rate counter=0; cts synchroniser=0.
- Frame format: start bit (0), then data bits 0..7 LSB first, then STOP_BITS stop bits (1).
  - Every bit lasts exactly BPS_COUNT cycles.
  - A full 8N1 frame is 10*BPS_COUNT cycles.
- tx_rdy_o is combinational from the queue count: it is 1 when count < FIFO_DEPTH.
  - tx_stb_i while tx_rdy_o=0 is ignored. The byte is dropped and the queue is unchanged.
  - This holds even if a pop occurs in the same cycle.
- Push and pop in the same cycle are legal when the queue is not full; the count is unchanged.
- Queue pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is one bit wider.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE -> START: queue non-empty && cts_sync && !tx_brk_i.
    - Pop the head into the 8-bit shift register.
    - Load the rate counter with BPS_COUNT-1.
    - tx_serial_o goes 0 on that same edge.
  - IDLE -> BREAK: tx_brk_i=1.
  - START -> DATA, when the rate counter reaches 0.
  - DATA: shift out 8 bits; a 3-bit bit counter runs 0..7. Leave to STOP after bit 7 has completed its period.
  - STOP: hold 1 for STOP_BITS*BPS_COUNT cycles, then go to IDLE.
  - BREAK: tx_serial_o=0 while tx_brk_i=1. When tx_brk_i drops, hold 1 for one full BPS_COUNT mark time, then go to IDLE.
- Latency: a write at edge N into an empty queue, with an idle FSM and cts_sync=1, drives the start bit from edge N+1.
- Back-to-back bytes: the next start bit follows the last stop bit with zero extra cycles.
- CTS is sampled only in IDLE. Deassertion mid-frame never truncates the current frame. Queued bytes wait until CTS returns.
- tx_brk_i asserted mid-frame is deferred: the current frame finishes, including stop bits, then the FSM enters BREAK. The queue is not drained during break.
- Rate counter width: $clog2(BPS_COUNT) bits, minimum 1. It counts down; a bit ends when the counter is 0 and it reloads BPS_COUNT-1.
- Asynchronous reset mid-frame aborts immediately: the line returns to 1 and queued bytes are discarded.

Decomposition:
- xosera_pkg: acia_tx_state_t enum (IDLE, START, DATA, STOP, BREAK). Also the BPS_COUNT computation as a shared function, so RX and TX compute identical bit periods.
- Sub-module acia_tx_fifo: parameterised synchronous FIFO.
  - Parameters: FIFO_DEPTH, width 8.
  - Ports: push/pop/full/empty.
  - Async active-low reset.
  - Instantiated once.

Test Plan:
(Bench parameters: CLK_HZ=1600000, BPS_RATE=100000, so BPS_COUNT=16.)
1. Write 0xA5, CTS=1.
   -> Line low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1.
   -> tx_busy_o drops 160 cycles after the start edge.
2. Write 0x00..0x04 on consecutive cycles with FIFO_DEPTH=4.
   -> tx_rdy_o stays 1. The first byte is popped at once, so all 5 bytes are accepted and rdy goes low after the 5th.
   -> 5 contiguous frames, 800 cycles, no idle gaps.
3. Queue full, then strobe 0xFF.
   -> Byte dropped; only the original 4 bytes appear on the line.
4. CTS=0, write 0x55.
   -> Line stays 1 and tx_busy_o=1.
   -> Raise CTS: the start bit begins 3 cycles later (2 sync + 1).
   -> Drop CTS mid-frame: the frame completes intact.
5. Assert tx_brk_i during bit 3 of 0x3C.
   -> Frame completes, then the line is 0 while brk is held.
   -> Release: 16 cycles of 1, then the next queued byte's start bit.
6. Pull rst_ni low mid-DATA.
   -> tx_serial_o=1 asynchronously, tx_rdy_o=1, tx_busy_o=0, and nothing is transmitted after release.
   -> STOP_BITS=2 variant of scenario 1: stop high for 32 cycles before the next start.
